// File: rtl/cic_decimator.sv
// Three-stage CIC decimator: integrators run on accepted input samples, combs run
// on the decimated strobe, output is the truncated top OSZ bits of the last comb.
module cic_decimator #(
    parameter int NUM_STAGES = 3,
    parameter int STG_GSZ    = 5,
    parameter int DEC_RATIO  = 32,
    parameter int ISZ        = 16,
    parameter int ASZ        = ISZ + NUM_STAGES * STG_GSZ,
    parameter int OSZ        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic signed [ISZ-1:0] in,
    output logic                  out_valid,
    output logic signed [OSZ-1:0] out
);

    localparam logic [STG_GSZ-1:0] CNT_MAX = STG_GSZ'(DEC_RATIO - 1);

    logic signed [ASZ-1:0] integ     [NUM_STAGES];
    logic signed [ASZ-1:0] integ_nxt [NUM_STAGES];
    logic signed [ASZ-1:0] comb_x    [NUM_STAGES];
    logic signed [ASZ-1:0] dly       [NUM_STAGES];
    logic signed [ASZ-1:0] diff      [NUM_STAGES];
    logic [STG_GSZ-1:0]    cnt;
    // vld[0] marks E0; vld[k] qualifies comb stage k on the following edge.
    logic [NUM_STAGES:0]   vld;

    // Each integrator accumulates its predecessor's updated value, so the last
    // stage already contains the sample accepted on the same edge.
    always_comb begin
        logic signed [ASZ-1:0] acc;
        // NOTE: a blocking temporary inside always_comb is fine; it carries no state.
        acc = ASZ'(in);
        for (int k = 0; k < NUM_STAGES; k++) begin
            acc          = integ[k] + acc;
            integ_nxt[k] = acc;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            diff[k] = comb_x[k] - dly[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: these arrays are state registers, so every element is cleared.
            for (int k = 0; k < NUM_STAGES; k++) begin
                integ[k]  <= '0;
                comb_x[k] <= '0;
                dly[k]    <= '0;
            end
            cnt       <= '0;
            vld       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    integ[k] <= integ_nxt[k];
                end
                cnt <= cnt + 1'b1;
            end

            vld <= {vld[NUM_STAGES-1:0], in_valid && (cnt == CNT_MAX)};

            if (vld[0]) begin
                comb_x[0] <= integ[NUM_STAGES-1];
            end

            for (int k = 1; k < NUM_STAGES; k++) begin
                if (vld[k]) begin
                    comb_x[k]  <= diff[k-1];
                    dly[k-1]   <= comb_x[k-1];
                end
            end

            // The final comb difference is truncated straight into the output register.
            if (vld[NUM_STAGES]) begin
                dly[NUM_STAGES-1] <= comb_x[NUM_STAGES-1];
                out               <= diff[NUM_STAGES-1][ASZ-1 -: OSZ];
            end
            out_valid <= vld[NUM_STAGES];
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: DC responses, gapped input, wrap, and reset behaviour,
// with expected values worked out by hand from the CIC step response.
module tb_cic_decimator;

    localparam int N   = 3;
    localparam int R   = 32;
    localparam int LAT = N + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] in;
    logic               out_valid;
    logic signed [15:0] out;

    always #5 clk = ~clk;

    cic_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .out_valid (out_valid),
        .out       (out)
    );

    int checks = 0;
    int errors = 0;

    int edge_cnt = 0;
    int accept_edges[$];
    int out_edges[$];
    int outs[$];
    int wide = 0;
    int unstable = 0;
    logic               prev_valid = 1'b0;
    logic signed [15:0] prev_out = '0;

    always @(posedge clk) begin
        edge_cnt++;
        if (in_valid === 1'b1 && reset === 1'b0) accept_edges.push_back(edge_cnt);
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            outs.push_back(int'(out));
            out_edges.push_back(edge_cnt);
            if (prev_valid === 1'b1) wide++;
        end else if (out !== prev_out) begin
            unstable++;
        end
        prev_valid = out_valid;
        prev_out   = out;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] get_out(input int i);
        if (i < outs.size()) return outs[i];
        return 'x;
    endfunction

    // Clears the monitor away from both clock edges, then returns on a falling edge.
    task automatic clear_mon();
        @(posedge clk);
        #1;
        accept_edges.delete();
        out_edges.delete();
        outs.delete();
        wide       = 0;
        unstable   = 0;
        prev_valid = out_valid;
        prev_out   = out;
        @(negedge clk);
    endtask

    task automatic run_samples(input logic signed [15:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in       = v;
            @(negedge clk);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        int bad = 0;
        for (int b = 0; b < outs.size(); b++) begin
            int idx = R * b + R - 1;
            if (idx >= accept_edges.size() || out_edges[b] - accept_edges[idx] != LAT) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_dc(input string tag, input int v, input int n_out);
        int bad = 0;
        check({tag, "_count"}, outs.size(), n_out);
        for (int i = 2; i < outs.size(); i++) begin
            if (outs[i] != v) bad++;
        end
        check({tag, "_steady"}, bad, 0);
        check({tag, "_wide"}, wide, 0);
        check({tag, "_unstable"}, unstable, 0);
    endtask

    initial begin
        // Reset with a sample offered at the same time: it must be ignored.
        reset    = 1'b1;
        in_valid = 1'b1;
        in       = 16'sd1024;
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        reset    = 1'b0;
        in_valid = 1'b0;

        // DC 1024, continuous input: 320 samples give 10 pulses.
        clear_mon();
        run_samples(16'sd1024, 320, 0);
        repeat (10) @(negedge clk);
        check("a_out0", get_out(0), 187);
        check("a_out1", get_out(1), 869);
        check("a_out2", get_out(2), 1024);
        check("a_out3", get_out(3), 1024);
        check_dc("a", 1024, 10);
        check_latency("a_latency");

        // Same DC with input accepted one cycle in three.
        pulse_reset();
        clear_mon();
        run_samples(16'sd1024, 128, 2);
        repeat (10) @(negedge clk);
        check("b_out0", get_out(0), 187);
        check("b_out1", get_out(1), 869);
        check("b_out2", get_out(2), 1024);
        check("b_out3", get_out(3), 1024);
        check("b_count", outs.size(), 4);
        check_latency("b_latency");

        // Full-scale DC long enough for every integrator to wrap.
        pulse_reset();
        clear_mon();
        run_samples(-16'sd32768, 33000, 0);
        repeat (10) @(negedge clk);
        check_dc("c_neg", -32768, 1031);

        pulse_reset();
        clear_mon();
        run_samples(16'sd32767, 33000, 0);
        repeat (10) @(negedge clk);
        check_dc("c_pos", 32767, 1031);

        // Reset while a block sits in the comb pipeline: no pulse may escape.
        pulse_reset();
        clear_mon();
        run_samples(16'sd1024, 33, 0);
        pulse_reset();
        repeat (8) @(negedge clk);
        check("d_inflight_pulses", outs.size(), 0);

        // Reset after 50 samples, then a fresh block restarts from zero.
        clear_mon();
        run_samples(16'sd1024, 50, 0);
        check("d_pre_out", out, 187);
        pulse_reset();
        check("d_post_out", out, 0);
        check("d_post_out_valid", {31'd0, out_valid}, 0);
        clear_mon();
        run_samples(16'sd1024, 32, 0);
        repeat (8) @(negedge clk);
        check("d_restart_count", outs.size(), 1);
        check("d_restart_out", get_out(0), 187);
        check_latency("d_restart_latency");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
